// File: rtl/ones_comp_seq_alu.sv
// ones_comp_seq_alu: multi-cycle ones'-complement ALU (AD/SU/MASK/MP/DV) with start/busy/done handshake.
// Optional feature macro PARITY_CHECK_EN: odd-parity check of the A/B operand words at capture.
module ones_comp_seq_alu #(
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       command,
  input  logic [WIDTH:0]   A,
  input  logic [WIDTH:0]   B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_lo,
  output logic             overflow,
  output logic             parity_err
);
  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] CMD_AD   = 3'd0;
  localparam logic [2:0] CMD_SU   = 3'd1;
  localparam logic [2:0] CMD_MASK = 3'd2;
  localparam logic [2:0] CMD_MP   = 3'd3;
  localparam logic [2:0] CMD_DV   = 3'd5;
  localparam logic [CW-1:0] LAST_ITER = CW'(M - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  // End-around-carry add; MSB of the return value is the signed overflow flag.
  function automatic logic [WIDTH:0] oc_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0]   raw;
    logic [WIDTH-1:0] sum;
    logic             ovf;
    raw = {1'b0, x} + {1'b0, y};
    sum = raw[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, raw[WIDTH]};
    ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    return {ovf, sum};
  endfunction

  function automatic logic [M-1:0] magnitude(input logic [WIDTH-1:0] w);
    return w[WIDTH-1] ? ~w[M-1:0] : w[M-1:0];
  endfunction

`ifdef PARITY_CHECK_EN
  function automatic logic odd_parity_ok(input logic [WIDTH:0] w);
    return ^w;
  endfunction
`endif

  state_t           state_r, state_n;
  logic [WIDTH-1:0] a_s, b_s;
  logic [M-1:0]     mag_a_s, mag_b_s;
  logic             in_perr_s;
  logic             is_div_r, is_div_n, a_sign_r, a_sign_n, q_sign_r, q_sign_n, perr_r, perr_n;
  logic [M-1:0]     opd_r, opd_n, hi_r, hi_n, lo_r, lo_n;
  logic [CW-1:0]    cnt_r, cnt_n;
  logic             busy_r, busy_n, done_r, done_n, ovf_r, ovf_n, perr_out_r, perr_out_n;
  logic [WIDTH-1:0] res_r, res_n, res_lo_r, res_lo_n;
  logic [M:0]       mul_sum_s, div_sh_s, div_diff_s;
  logic             div_ge_s;
  logic [M-1:0]     step_hi_s, step_lo_s;
  logic [WIDTH-1:0] fin_res_s, fin_lo_s, out_res_s, out_lo_s;
  logic             out_ovf_s, out_perr_s;
  logic [WIDTH:0]   add_s;

  assign a_s     = A[WIDTH:1];
  assign b_s     = B[WIDTH:1];
  assign mag_a_s = magnitude(a_s);
  assign mag_b_s = magnitude(b_s);

`ifdef PARITY_CHECK_EN
  assign in_perr_s = !(odd_parity_ok(A) && odd_parity_ok(B));
`else
  assign in_perr_s = 1'b0;
`endif

  // One shift-add (multiply) or restoring-subtract (divide) iteration on the working pair hi/lo.
  always_comb begin
    mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opd_r} : {(M+1){1'b0}});
    div_sh_s   = {hi_r, lo_r[M-1]};
    div_diff_s = div_sh_s - {1'b0, opd_r};
    div_ge_s   = (div_sh_s >= {1'b0, opd_r});
    step_hi_s  = {M{1'b0}};
    step_lo_s  = {M{1'b0}};
    fin_res_s  = {WIDTH{1'b0}};
    fin_lo_s   = {WIDTH{1'b0}};
    if (is_div_r) begin
      step_hi_s = div_ge_s ? div_diff_s[M-1:0] : div_sh_s[M-1:0];
      step_lo_s = {lo_r[M-2:0], div_ge_s};
      fin_res_s = {1'b0, step_lo_s} ^ {WIDTH{q_sign_r}};
      fin_lo_s  = {1'b0, step_hi_s} ^ {WIDTH{a_sign_r}};
    end else begin
      step_hi_s = mul_sum_s[M:1];
      step_lo_s = {mul_sum_s[0], lo_r[M-1:1]};
      fin_res_s = {1'b0, step_hi_s} ^ {WIDTH{q_sign_r}};
      fin_lo_s  = {1'b0, step_lo_s} ^ {WIDTH{q_sign_r}};
    end
  end

  // Next-state and next-register logic; outputs reload only on entry to DONE.
  always_comb begin
    state_n    = state_r;
    is_div_n   = is_div_r;
    a_sign_n   = a_sign_r;
    q_sign_n   = q_sign_r;
    perr_n     = perr_r;
    opd_n      = opd_r;
    hi_n       = hi_r;
    lo_n       = lo_r;
    cnt_n      = cnt_r;
    add_s      = {(WIDTH+1){1'b0}};
    out_res_s  = {WIDTH{1'b0}};
    out_lo_s   = {WIDTH{1'b0}};
    out_ovf_s  = 1'b0;
    out_perr_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          a_sign_n   = a_s[WIDTH-1];
          q_sign_n   = a_s[WIDTH-1] ^ b_s[WIDTH-1];
          perr_n     = in_perr_s;
          out_perr_s = in_perr_s;
          cnt_n      = {CW{1'b0}};
          hi_n       = {M{1'b0}};
          state_n    = DONE;
          case (command)
            CMD_AD: begin
              add_s     = oc_add(a_s, b_s);
              out_res_s = add_s[WIDTH-1:0];
              out_ovf_s = add_s[WIDTH];
            end
            CMD_SU: begin
              add_s     = oc_add(a_s, ~b_s);
              out_res_s = add_s[WIDTH-1:0];
              out_ovf_s = add_s[WIDTH];
            end
            CMD_MASK: out_res_s = a_s & b_s;
            CMD_MP: begin
              is_div_n = 1'b0;
              opd_n    = mag_a_s;
              lo_n     = mag_b_s;
              state_n  = CALC;
            end
            CMD_DV: begin
              if (mag_b_s == {M{1'b0}}) begin
                out_res_s = {1'b0, {M{1'b1}}} ^ {WIDTH{a_s[WIDTH-1] ^ b_s[WIDTH-1]}};
                out_ovf_s = 1'b1;
              end else begin
                is_div_n = 1'b1;
                opd_n    = mag_b_s;
                lo_n     = mag_a_s;
                state_n  = CALC;
              end
            end
            default: out_res_s = {WIDTH{1'b0}};
          endcase
        end else begin
          state_n = IDLE;
        end
      end
      CALC: begin
        hi_n  = step_hi_s;
        lo_n  = step_lo_s;
        cnt_n = cnt_r + CW'(1);
        if (cnt_r == LAST_ITER) begin
          state_n    = DONE;
          out_res_s  = fin_res_s;
          out_lo_s   = fin_lo_s;
          out_perr_s = perr_r;
        end else begin
          state_n = CALC;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
    if (state_n == DONE) begin
      res_n      = out_res_s;
      res_lo_n   = out_lo_s;
      ovf_n      = out_ovf_s;
      perr_out_n = out_perr_s;
    end else begin
      res_n      = res_r;
      res_lo_n   = res_lo_r;
      ovf_n      = ovf_r;
      perr_out_n = perr_out_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_n;
  end

  // Operand, iteration and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_div_r   <= 1'b0;
      a_sign_r   <= 1'b0;
      q_sign_r   <= 1'b0;
      perr_r     <= 1'b0;
      opd_r      <= {M{1'b0}};
      hi_r       <= {M{1'b0}};
      lo_r       <= {M{1'b0}};
      cnt_r      <= {CW{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ovf_r      <= 1'b0;
      perr_out_r <= 1'b0;
      res_r      <= {WIDTH{1'b0}};
      res_lo_r   <= {WIDTH{1'b0}};
    end else begin
      is_div_r   <= is_div_n;
      a_sign_r   <= a_sign_n;
      q_sign_r   <= q_sign_n;
      perr_r     <= perr_n;
      opd_r      <= opd_n;
      hi_r       <= hi_n;
      lo_r       <= lo_n;
      cnt_r      <= cnt_n;
      busy_r     <= busy_n;
      done_r     <= done_n;
      ovf_r      <= ovf_n;
      perr_out_r <= perr_out_n;
      res_r      <= res_n;
      res_lo_r   <= res_lo_n;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign result     = res_r;
  assign result_lo  = res_lo_r;
  assign overflow   = ovf_r;
  assign parity_err = perr_out_r;

endmodule
